// File: rtl/mac_feeder_pkg.sv
// Shared definitions for the MAC operand feeder: operand/accumulator widths,
// FSM state encodings and the operand-pair record.
package mac_feeder_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned ACC_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } pair_t;

    function automatic logic [ACC_W-1:0] pair_product(input logic [OP_W-1:0] a,
                                                     input logic [OP_W-1:0] b);
        return ACC_W'(a) * ACC_W'(b);
    endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Operand-pair push bus into the feeder: valid/ready handshake plus A/B operands.
interface mac_feeder_if;

    logic                             in_valid;
    logic                             in_ready;
    logic [mac_feeder_pkg::OP_W-1:0] in_A;
    logic [mac_feeder_pkg::OP_W-1:0] in_B;

    modport master (
        output in_valid,
        output in_A,
        output in_B,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_A,
        input  in_B,
        output in_ready
    );

endinterface

// File: rtl/mac_feeder_fifo.sv
// Synchronous operand-pair FIFO with wrap-around pointers and an occupancy count.
// Pushes are dropped when full; pops are ignored when empty.
module mac_feeder_fifo
    import mac_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  pair_t            wr_data_i,
    output pair_t            rd_data_o,
    output logic             full_o,
    output logic [CNT_W-1:0] level_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    pair_t            mem_q [DEPTH];
    pair_t            mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (level_q == FULL_LVL);
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & (level_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// Operand sequencer for the 2-bit MAC: buffers pairs, clears the MAC and streams a job.
// Optional MAC_FEEDER_SHADOW_EN adds exp_sum, a shadow of the expected MAC result.
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             Reset,
    mac_feeder_if.slave      in_bus,
    input  logic             start,
    output logic [OP_W-1:0]  A,
    output logic [OP_W-1:0]  B,
    output logic             y,
    output logic             nClr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] level
`ifdef MAC_FEEDER_SHADOW_EN
    ,
    output logic [ACC_W-1:0] exp_sum
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;
    logic             y_req_q, y_req_d;
    logic             nclr_q, nclr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             y_q, y_d;
    logic             pop;
    logic             fifo_full;
    pair_t            head;
    pair_t            wr_pair;

    assign wr_pair.a       = in_bus.in_A;
    assign wr_pair.b       = in_bus.in_B;
    assign in_bus.in_ready = ~fifo_full;

    mac_feeder_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .push_i    (in_bus.in_valid),
        .pop_i     (pop),
        .wr_data_i (wr_pair),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .level_o   (level)
    );

    // Outputs are registered with the state they belong to, so each branch
    // sets the values for the state being entered.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        a_d     = a_q;
        b_d     = b_q;
        y_req_d = 1'b0;
        nclr_d  = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = CLEAR;
                    rem_d   = level;
                    nclr_d  = 1'b0;
                    busy_d  = 1'b1;
                    a_d     = '0;
                    b_d     = '0;
                end
            end
            CLEAR, RUN: begin
                if (rem_q != '0) begin
                    state_d = RUN;
                    pop     = 1'b1;
                    a_d     = head.a;
                    b_d     = head.b;
                    y_req_d = 1'b1;
                    rem_d   = rem_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    a_d     = '0;
                    b_d     = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_req_q <= 1'b0;
            nclr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_req_q <= y_req_d;
            nclr_q  <= nclr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Falling-edge relaunch keeps y constant while clk is high (MAC gates clk&y).
    assign y_d = y_req_q;

    always_ff @(negedge clk or posedge Reset) begin
        if (Reset) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign y    = y_q;
    assign nClr = nclr_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef MAC_FEEDER_SHADOW_EN
    logic [ACC_W-1:0] exp_q, exp_d;

    always_comb begin
        exp_d = exp_q;
        if (state_q == CLEAR) begin
            exp_d = '0;
        end else if (y_req_q) begin
            exp_d = exp_q + pair_product(a_q, b_q);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp_sum = exp_q;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural 2-bit MAC on its outputs.
module tb_mac_feeder;

    logic       clk;
    logic       Reset;
    logic       start;
    logic [1:0] A;
    logic [1:0] B;
    logic       y;
    logic       nClr;
    logic       busy;
    logic       done;
    logic [3:0] level;
    logic [7:0] mac_out;
`ifdef MAC_FEEDER_SHADOW_EN
    logic [7:0] exp_sum;
`endif

    int checks;
    int errors;

    mac_feeder_if in_if ();

    mac_feeder #(
        .DEPTH (8),
        .CNT_W (4)
    ) dut (
        .clk     (clk),
        .Reset   (Reset),
        .in_bus  (in_if),
        .start   (start),
        .A       (A),
        .B       (B),
        .y       (y),
        .nClr    (nClr),
        .busy    (busy),
`ifdef MAC_FEEDER_SHADOW_EN
        .exp_sum (exp_sum),
`endif
        .done    (done),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: async clear on nClr low, accumulates A*B on clk&y.
    always @(posedge clk or negedge nClr) begin
        if (!nClr) mac_out <= 8'd0;
        else if (y) mac_out <= mac_out + ({6'd0, A} * {6'd0, B});
    end

    always @(y) begin
        if (Reset === 1'b0 && $time > 0) begin
            checks++;
            if (clk === 1'b1) begin
                errors++;
                $display("FAIL y_glitch: y changed to %b while clk=1 at t=%0t", y, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] b);
        in_if.in_valid = 1'b1;
        in_if.in_A     = a;
        in_if.in_B     = b;
        tick();
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, done, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
        checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_if.in_ready); end
        checks++; if ({A, B} !== 4'd0) begin errors++; $display("FAIL rst_AB: got %0d/%0d want 0/0", A, B); end
        checks++; if ({y, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_ybd: got %b%b%b want 000", y, busy, done); end
        checks++; if (nClr !== 1'b0) begin errors++; $display("FAIL rst_nclr: got %b want 0", nClr); end
        Reset = 1'b0;
        #1;
        checks++; if (nClr !== 1'b0) begin errors++; $display("FAIL rst_nclr_hold: got %b want 0", nClr); end
        tick();
        checks++; if (nClr !== 1'b1) begin errors++; $display("FAIL rst_nclr_release: got %b want 1", nClr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_job3();
        logic [1:0] ea [3];
        logic [1:0] eb [3];
        ea = '{2'd1, 2'd2, 2'd3};
        eb = '{2'd1, 2'd3, 2'd3};
        for (int i = 0; i < 3; i++) push(ea[i], eb[i]);
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL job3_level: got %0d want 3", level); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({nClr, busy} !== 2'b01) begin errors++; $display("FAIL job3_clear: nClr/busy=%b%b want 01", nClr, busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({A, B} !== {ea[i], eb[i]}) begin errors++; $display("FAIL job3_pair%0d: got %0d/%0d want %0d/%0d", i, A, B, ea[i], eb[i]); end
            checks++; if ({nClr, done} !== 2'b10) begin errors++; $display("FAIL job3_run%0d: nClr/done=%b%b want 10", i, nClr, done); end
            @(negedge clk);
            #1;
            checks++; if (y !== 1'b1) begin errors++; $display("FAIL job3_y%0d: got %b want 1", i, y); end
        end
        tick();
        checks++; if ({done, busy} !== 2'b11) begin errors++; $display("FAIL job3_done: done/busy=%b%b want 11", done, busy); end
        checks++; if (mac_out !== 8'd16) begin errors++; $display("FAIL job3_out: got %0d want 16", mac_out); end
`ifdef MAC_FEEDER_SHADOW_EN
        checks++; if (exp_sum !== 8'd16) begin errors++; $display("FAIL job3_exp: got %0d want 16", exp_sum); end
`endif
        tick();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL job3_idle: done/busy=%b%b want 00", done, busy); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL job3_level_end: got %0d want 0", level); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 9; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_A     = 2'd3;
            in_if.in_B     = 2'd3;
            checks++;
            if (in_if.in_ready !== (i < 8)) begin
                errors++;
                $display("FAIL full_ready%0d: got %b want %b", i, in_if.in_ready, (i < 8));
            end
            tick();
        end
        in_if.in_valid = 1'b0;
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", level); end
        checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_end: got %b want 0", in_if.in_ready); end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, "full");
        checks++; if (mac_out !== 8'd72) begin errors++; $display("FAIL full_out: got %0d want 72", mac_out); end
`ifdef MAC_FEEDER_SHADOW_EN
        checks++; if (exp_sum !== 8'd72) begin errors++; $display("FAIL full_exp: got %0d want 72", exp_sum); end
`endif
        tick();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL full_level_end: got %0d want 0", level); end
    endtask

    task automatic test_zero_len();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({nClr, busy, done} !== 3'b010) begin errors++; $display("FAIL zero_clear: nClr/busy/done=%b%b%b want 010", nClr, busy, done); end
        @(negedge clk);
        #1;
        checks++; if (y !== 1'b0) begin errors++; $display("FAIL zero_y0: got %b want 0", y); end
        tick();
        checks++; if ({busy, done} !== 2'b11) begin errors++; $display("FAIL zero_done: busy/done=%b%b want 11", busy, done); end
        checks++; if (mac_out !== 8'd0) begin errors++; $display("FAIL zero_out: got %0d want 0", mac_out); end
        @(negedge clk);
        #1;
        checks++; if (y !== 1'b0) begin errors++; $display("FAIL zero_y1: got %b want 0", y); end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_idle: busy/done=%b%b want 00", busy, done); end
    endtask

    task automatic test_concurrent();
        push(2'd2, 2'd2);
        push(2'd1, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if ({A, B} !== {2'd2, 2'd2}) begin errors++; $display("FAIL conc_pair0: got %0d/%0d want 2/2", A, B); end
        in_if.in_valid = 1'b1;
        in_if.in_A     = 2'd3;
        in_if.in_B     = 2'd1;
        start          = 1'b1;
        tick();
        in_if.in_valid = 1'b0;
        start          = 1'b0;
        checks++; if ({A, B} !== {2'd1, 2'd3}) begin errors++; $display("FAIL conc_pair1: got %0d/%0d want 1/3", A, B); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL conc_level_run: got %0d want 1", level); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL conc_done: got %b want 1", done); end
        checks++; if (mac_out !== 8'd7) begin errors++; $display("FAIL conc_out: got %0d want 7", mac_out); end
`ifdef MAC_FEEDER_SHADOW_EN
        checks++; if (exp_sum !== 8'd7) begin errors++; $display("FAIL conc_exp: got %0d want 7", exp_sum); end
`endif
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL conc_level_done: got %0d want 1", level); end
        tick();
        checks++; if ({busy, done, nClr} !== 3'b001) begin errors++; $display("FAIL conc_start_ignored: busy/done/nClr=%b%b%b want 001", busy, done, nClr); end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10, "conc2");
        checks++; if (mac_out !== 8'd3) begin errors++; $display("FAIL conc2_out: got %0d want 3", mac_out); end
`ifdef MAC_FEEDER_SHADOW_EN
        checks++; if (exp_sum !== 8'd3) begin errors++; $display("FAIL conc2_exp: got %0d want 3", exp_sum); end
`endif
        tick();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL conc2_level: got %0d want 0", level); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) push(2'd1, 2'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++; if ({busy, y} !== 2'b11) begin errors++; $display("FAIL mid_running: busy/y=%b%b want 11", busy, y); end
        checks++; if (mac_out !== 8'd2) begin errors++; $display("FAIL mid_partial: got %0d want 2", mac_out); end
        Reset = 1'b1;
        #1;
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", level); end
        checks++; if ({y, nClr, busy} !== 3'b000) begin errors++; $display("FAIL mid_outs: y/nClr/busy=%b%b%b want 000", y, nClr, busy); end
        checks++; if (mac_out !== 8'd0) begin errors++; $display("FAIL mid_out: got %0d want 0", mac_out); end
        tick();
        Reset = 1'b0;
        tick();
        checks++; if ({nClr, busy, done} !== 3'b100) begin errors++; $display("FAIL mid_release: nClr/busy/done=%b%b%b want 100", nClr, busy, done); end
        checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", in_if.in_ready); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        Reset          = 1'b1;
        start          = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_A     = 2'd0;
        in_if.in_B     = 2'd0;
        test_reset();
        test_job3();
        test_full();
        test_zero_len();
        test_concurrent();
        test_mid_reset();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
